// File: rtl/sort_unit_flex_pkg.sv
// sort_unit_flex shared definitions.
// Stage bundle carries valid, order and four max-width elements.
package sort_unit_flex_pkg;

    localparam int NUM_ELEMS  = 4;
    localparam int NUM_STAGES = 3;
    localparam int MAX_NBITS  = 64;

    typedef logic [MAX_NBITS-1:0] elem_t;

    typedef struct packed {
        logic                        valid;
        logic                        desc;
        elem_t [NUM_ELEMS-1:0]       elem;
    } stage_t;

endpackage

// File: rtl/sort_unit_flex_minmax.sv
// One compare-exchange: first/second are min/max,
// or max/min when desc is set.
module sort_unit_flex_minmax #(
    parameter int p_nbits  = 8,
    parameter int p_signed = 0
) (
    input  logic [p_nbits-1:0] a,
    input  logic [p_nbits-1:0] b,
    input  logic               desc,
    output logic [p_nbits-1:0] first,
    output logic [p_nbits-1:0] second
);

    logic               a_gt_b;
    logic [p_nbits-1:0] lo;
    logic [p_nbits-1:0] hi;

    // full-width compare in the configured signedness, then route
    always_comb begin
        if (p_signed != 0) begin
            a_gt_b = $signed(a) > $signed(b);
        end else begin
            a_gt_b = a > b;
        end
        lo     = a_gt_b ? b : a;
        hi     = a_gt_b ? a : b;
        first  = desc ? hi : lo;
        second = desc ? lo : hi;
    end

endmodule

// File: rtl/sort_unit_flex.sv
// sort_unit_flex: 3-stage four-element sorting network, global stall.
// Macro SORT_UNIT_FLEX_PERF_EN enables the num_sorted transfer counter.
import sort_unit_flex_pkg::*;

module sort_unit_flex #(
    parameter int p_nbits  = 8,
    parameter int p_signed = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_val,
    output logic               in_rdy,
    input  logic [p_nbits-1:0] in0,
    input  logic [p_nbits-1:0] in1,
    input  logic [p_nbits-1:0] in2,
    input  logic [p_nbits-1:0] in3,
    input  logic               in_desc,
    output logic               out_val,
    input  logic               out_rdy,
    output logic [p_nbits-1:0] out0,
    output logic [p_nbits-1:0] out1,
    output logic [p_nbits-1:0] out2,
    output logic [p_nbits-1:0] out3,
    output logic [31:0]        num_sorted
);

    stage_t stg [NUM_STAGES];
    stage_t nxt [NUM_STAGES];
    logic   go;
    logic   unused_bits;

    logic [p_nbits-1:0] f01, s01, f23, s23;
    logic [p_nbits-1:0] fa, sa, fb, sb;
    logic [p_nbits-1:0] fm, sm;

    assign go      = !stg[2].valid || out_rdy;
    assign in_rdy  = go;
    assign out_val = stg[2].valid;

    assign out0 = stg[2].valid ? stg[2].elem[0][p_nbits-1:0] : '0;
    assign out1 = stg[2].valid ? stg[2].elem[1][p_nbits-1:0] : '0;
    assign out2 = stg[2].valid ? stg[2].elem[2][p_nbits-1:0] : '0;
    assign out3 = stg[2].valid ? stg[2].elem[3][p_nbits-1:0] : '0;

    sort_unit_flex_minmax #(.p_nbits(p_nbits), .p_signed(p_signed)) u_m01 (
        .a(in0), .b(in1), .desc(in_desc), .first(f01), .second(s01)
    );
    sort_unit_flex_minmax #(.p_nbits(p_nbits), .p_signed(p_signed)) u_m23 (
        .a(in2), .b(in3), .desc(in_desc), .first(f23), .second(s23)
    );
    sort_unit_flex_minmax #(.p_nbits(p_nbits), .p_signed(p_signed)) u_ma (
        .a(stg[0].elem[0][p_nbits-1:0]), .b(stg[0].elem[2][p_nbits-1:0]),
        .desc(stg[0].desc), .first(fa), .second(sa)
    );
    sort_unit_flex_minmax #(.p_nbits(p_nbits), .p_signed(p_signed)) u_mb (
        .a(stg[0].elem[1][p_nbits-1:0]), .b(stg[0].elem[3][p_nbits-1:0]),
        .desc(stg[0].desc), .first(fb), .second(sb)
    );
    sort_unit_flex_minmax #(.p_nbits(p_nbits), .p_signed(p_signed)) u_mm (
        .a(stg[1].elem[1][p_nbits-1:0]), .b(stg[1].elem[2][p_nbits-1:0]),
        .desc(stg[1].desc), .first(fm), .second(sm)
    );

    // next contents of each stage; element bits above p_nbits stay zero
    always_comb begin
        nxt[0]       = '0;
        nxt[0].valid = in_val;
        nxt[0].desc  = in_desc;
        nxt[0].elem[0][p_nbits-1:0] = f01;
        nxt[0].elem[1][p_nbits-1:0] = s01;
        nxt[0].elem[2][p_nbits-1:0] = f23;
        nxt[0].elem[3][p_nbits-1:0] = s23;

        nxt[1]       = '0;
        nxt[1].valid = stg[0].valid;
        nxt[1].desc  = stg[0].desc;
        nxt[1].elem[0][p_nbits-1:0] = fa;
        nxt[1].elem[1][p_nbits-1:0] = sa;
        nxt[1].elem[2][p_nbits-1:0] = fb;
        nxt[1].elem[3][p_nbits-1:0] = sb;

        nxt[2] = stg[1];
        nxt[2].elem[1][p_nbits-1:0] = fm;
        nxt[2].elem[2][p_nbits-1:0] = sm;
    end

    // stage registers advance together whenever the output is free
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_STAGES; i++) begin
                stg[i] <= '0;
            end
        end else if (go) begin
            stg <= nxt;
        end
    end

    // padding bits and the final-stage order flag have no reader
    always_comb begin
        unused_bits = stg[2].desc;
        for (int s = 0; s < NUM_STAGES; s++) begin
            for (int e = 0; e < NUM_ELEMS; e++) begin
                unused_bits = unused_bits ^ (|(stg[s].elem[e] >> p_nbits));
            end
        end
    end

`ifdef SORT_UNIT_FLEX_PERF_EN
    // count completed output transfers, wrapping at 2^32
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            num_sorted <= '0;
        end else if (out_val && out_rdy) begin
            num_sorted <= num_sorted + 32'd1;
        end
    end
`else
    assign num_sorted = '0;
`endif

endmodule

// File: tb/tb_sort_unit_flex.sv
// Bench for sort_unit_flex: unsigned and signed instances share stimulus.
// A queue model with per-transaction age predicts handshakes and results.
module tb_sort_unit_flex;

    logic       clk;
    logic       reset;
    logic       in_val;
    logic [7:0] in0, in1, in2, in3;
    logic       in_desc;
    logic       out_rdy;

    logic        in_rdy_u, out_val_u;
    logic [7:0]  o0_u, o1_u, o2_u, o3_u;
    logic [31:0] ns_u;
    logic        in_rdy_s, out_val_s;
    logic [7:0]  o0_s, o1_s, o2_s, o3_s;
    logic [31:0] ns_s;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] ru;
        logic [31:0] rs;
        int          age;
    } txn_t;

    txn_t q[$];
    int   nsort = 0;

    sort_unit_flex #(.p_nbits(8), .p_signed(0)) u_uns (
        .clk(clk), .reset(reset), .in_val(in_val), .in_rdy(in_rdy_u),
        .in0(in0), .in1(in1), .in2(in2), .in3(in3), .in_desc(in_desc),
        .out_val(out_val_u), .out_rdy(out_rdy),
        .out0(o0_u), .out1(o1_u), .out2(o2_u), .out3(o3_u),
        .num_sorted(ns_u)
    );

    sort_unit_flex #(.p_nbits(8), .p_signed(1)) u_sgn (
        .clk(clk), .reset(reset), .in_val(in_val), .in_rdy(in_rdy_s),
        .in0(in0), .in1(in1), .in2(in2), .in3(in3), .in_desc(in_desc),
        .out_val(out_val_s), .out_rdy(out_rdy),
        .out0(o0_s), .out1(o1_s), .out2(o2_s), .out3(o3_s),
        .num_sorted(ns_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference: rank the four values numerically, then list in order
    function automatic logic [31:0] sort4(logic [3:0][7:0] v, bit desc, bit sgn);
        int k[4];
        int t;
        logic [3:0][7:0] r;
        for (int i = 0; i < 4; i++)
            k[i] = sgn ? int'($signed(v[i])) : int'({24'b0, v[i]});
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3 - i; j++)
                if (k[j] > k[j+1]) begin
                    t = k[j]; k[j] = k[j+1]; k[j+1] = t;
                end
        for (int i = 0; i < 4; i++)
            r[i] = desc ? 8'(k[3-i]) : 8'(k[i]);
        return r;
    endfunction

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(bit v, logic [7:0] a, logic [7:0] b,
                         logic [7:0] c, logic [7:0] d, bit ds, bit ordy);
        in_val  = v;
        in0     = a;
        in1     = b;
        in2     = c;
        in3     = d;
        in_desc = ds;
        out_rdy = ordy;
    endtask

    task automatic check_reset_state(string tag);
        check({tag, "_val_u"}, out_val_u, 1'b0);
        check({tag, "_val_s"}, out_val_s, 1'b0);
        check({tag, "_rdy_u"}, in_rdy_u, 1'b1);
        check({tag, "_rdy_s"}, in_rdy_s, 1'b1);
        check({tag, "_data_u"}, {o3_u, o2_u, o1_u, o0_u}, 32'h0);
        check({tag, "_data_s"}, {o3_s, o2_s, o1_s, o0_s}, 32'h0);
        check({tag, "_ns_u"}, ns_u, 32'h0);
        check({tag, "_ns_s"}, ns_s, 32'h0);
    endtask

    // one clock: compare against the model, then advance it
    task automatic tick(output bit acc);
        bit   vis;
        bit   go;
        logic [31:0] exp_ns;
        #1;
        vis = (q.size() > 0) && (q[0].age == 3);
        go  = !vis || out_rdy;
`ifdef SORT_UNIT_FLEX_PERF_EN
        exp_ns = nsort;
`else
        exp_ns = 32'h0;
`endif
        check("in_rdy_u", in_rdy_u, go);
        check("in_rdy_s", in_rdy_s, go);
        check("out_val_u", out_val_u, vis);
        check("out_val_s", out_val_s, vis);
        check("data_u", {o3_u, o2_u, o1_u, o0_u}, vis ? q[0].ru : 32'h0);
        check("data_s", {o3_s, o2_s, o1_s, o0_s}, vis ? q[0].rs : 32'h0);
        check("num_sorted_u", ns_u, exp_ns);
        check("num_sorted_s", ns_s, exp_ns);
        acc = go && in_val;
        if (go) begin
            if (vis) begin
                void'(q.pop_front());
                nsort++;
            end
            foreach (q[i]) q[i].age = q[i].age + 1;
            if (in_val)
                q.push_back('{sort4({in3, in2, in1, in0}, in_desc, 0),
                              sort4({in3, in2, in1, in0}, in_desc, 1), 1});
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(int n);
        bit acc;
        for (int i = 0; i < n; i++) begin
            drive(0, 0, 0, 0, 0, 0, 1);
            tick(acc);
        end
    endtask

    initial begin
        bit acc;
        int sent;
        int c;
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 1);
        @(negedge clk);
        #1;
        check_reset_state("reset");
        reset = 1'b0;

        // ascending basic, then latency/drain
        drive(1, 8'h04, 8'h02, 8'h03, 8'h01, 0, 1);
        tick(acc);
        check("first_accept", acc, 1'b1);
        idle(2);
        check("latency_val", out_val_u, 1'b1);
        check("latency_data", {o3_u, o2_u, o1_u, o0_u}, 32'h04030201);
        idle(2);

        // descending then ascending back-to-back
        drive(1, 8'h04, 8'h02, 8'h03, 8'h01, 1, 1);
        tick(acc);
        drive(1, 8'h04, 8'h02, 8'h03, 8'h01, 0, 1);
        tick(acc);
        idle(4);

        // signedness and equal elements
        drive(1, 8'hff, 8'h01, 8'h80, 8'h00, 0, 1);
        tick(acc);
        drive(1, 8'h05, 8'h05, 8'h05, 8'h05, 1, 1);
        tick(acc);
        drive(1, 8'h07, 8'h03, 8'h07, 8'h03, 0, 1);
        tick(acc);
        drive(1, 8'h80, 8'h7f, 8'h80, 8'hff, 1, 1);
        tick(acc);
        idle(4);

        // backpressure: five back-to-back inputs, consumer stalls 4 cycles
        sent = 0;
        c = 0;
        while (sent < 5 && c < 40) begin
            drive(1, 8'h10 + 8'(sent), 8'h30 - 8'(sent), 8'(sent * 5),
                  8'h80, sent[0], !(c >= 3 && c < 7));
            tick(acc);
            if (acc) sent++;
            c++;
        end
        check("bp_all_sent", sent, 5);
        idle(6);

        // randomized traffic with random backpressure
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0)
                drive($urandom_range(0, 1),
                      8'($urandom_range(0, 3)), 8'($urandom_range(0, 3)),
                      8'($urandom_range(0, 3)), 8'($urandom_range(0, 3)),
                      $urandom_range(0, 1), $urandom_range(0, 3) != 0);
            else
                drive($urandom_range(0, 3) != 0,
                      8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                      $urandom_range(0, 1), $urandom_range(0, 2) != 0);
            tick(acc);
        end
        idle(6);

        // reset with three transactions in flight
        drive(1, 8'h09, 8'h08, 8'h07, 8'h06, 0, 1);
        tick(acc);
        drive(1, 8'h01, 8'h02, 8'h03, 8'h04, 1, 1);
        tick(acc);
        drive(1, 8'h44, 8'h11, 8'h33, 8'h22, 0, 1);
        tick(acc);
        drive(0, 0, 0, 0, 0, 0, 1);
        reset = 1'b1;
        #1;
        check_reset_state("mid_reset");
        q.delete();
        nsort = 0;
        @(posedge clk);
        @(negedge clk);
        check_reset_state("held_reset");
        reset = 1'b0;
        drive(1, 8'hc0, 8'h0a, 8'h55, 8'h0b, 1, 1);
        tick(acc);
        check("post_reset_accept", acc, 1'b1);
        idle(6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
